// File: rtl/pc_fetch_if.sv
// Instruction-fetch bus bundle: next-PC input, downstream handshake,
// instruction-memory read port, and the fetch status outputs.
interface pc_fetch_if;
    logic [31:0] proximo_pc;        // next PC chosen by the next-PC mux
    logic        avanca;            // downstream takes the held instruction
    logic [31:0] mem_dado;          // instruction memory read data
    logic        mem_pronto;        // instruction memory acknowledge
    logic        mem_req;           // instruction memory read request
    logic [31:0] mem_endereco;      // read address, mirrors pc_atual
    logic [31:0] pc_atual;          // current PC
    logic [31:0] instrucao;         // last fetched instruction
    logic        instrucao_valida;  // instrucao not yet delivered
    logic        parado;            // fetch halted

    // Environment side: supplies next PC, handshake and memory responses.
    modport master (
        output proximo_pc,
        output avanca,
        output mem_dado,
        output mem_pronto,
        input  mem_req,
        input  mem_endereco,
        input  pc_atual,
        input  instrucao,
        input  instrucao_valida,
        input  parado
    );

    // Fetch unit side.
    modport slave (
        input  proximo_pc,
        input  avanca,
        input  mem_dado,
        input  mem_pronto,
        output mem_req,
        output mem_endereco,
        output pc_atual,
        output instrucao,
        output instrucao_valida,
        output parado
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage. Holds the PC, requests one instruction from
// memory, presents it downstream until accepted, then loads the PC from the
// external next-PC mux. A fetched HALT opcode, once accepted, stops fetch
// until reset. No PC arithmetic is done here.
module pc_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input logic    clock,
    input logic    reset,   // synchronous, active-low
    pc_fetch_if.slave bus
);

    localparam logic [1:0] BUSCA   = 2'b00;  // request outstanding
    localparam logic [1:0] ENTREGA = 2'b01;  // instruction held for downstream
    localparam logic [1:0] PARADO  = 2'b10;  // halted until reset

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        halt_seen;

    assign halt_seen = (instr_q[31:26] == HALT_OPCODE);

    // Next-state and next-register values; each input is only looked at in
    // the one state where it has meaning.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            BUSCA: begin
                if (bus.mem_pronto) begin
                    instr_d = bus.mem_dado;
                    state_d = ENTREGA;
                end
            end
            ENTREGA: begin
                if (bus.avanca) begin
                    if (halt_seen) begin
                        state_d = PARADO;
                    end else begin
                        pc_d    = bus.proximo_pc;
                        state_d = BUSCA;
                    end
                end
            end
            PARADO: begin
                state_d = PARADO;
            end
            default: begin
                // Unused encoding: recover by refetching at the current PC.
                state_d = BUSCA;
            end
        endcase
    end

    // State, PC and instruction registers; reset wins over every input.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q <= BUSCA;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs are decoded purely from state and registers.
    assign bus.mem_req          = (state_q == BUSCA);
    assign bus.instrucao_valida = (state_q == ENTREGA);
    assign bus.parado           = (state_q == PARADO);
    assign bus.pc_atual         = pc_q;
    assign bus.mem_endereco     = pc_q;
    assign bus.instrucao        = instr_q;

endmodule
